// File: rtl/nco_cnt_mux_disp.sv
// NCO-paced BCD up/down counter driving a multiplexed 7-segment display.
// The NCO overflow pulse (o_tick) is the count enable; display outputs are registered.
module nco_cnt_mux_disp #(
  parameter int NUM_DIGIT = 6,
  parameter int NCO_W     = 32,
  parameter int SCAN_DIV  = 50000,
  parameter int DP_POS    = 2,
  parameter int LZ_BLANK  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCO_W-1:0]       i_nco_num,
  input  logic                   i_run,
  input  logic                   i_up,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic [4*NUM_DIGIT-1:0] i_load_val,
  output logic [6:0]             o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIGIT-1:0]   o_seg_enb,
  output logic                   o_tick,
  output logic                   o_wrap
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGIT);

  logic [NCO_W-1:0]            acc_q, acc_d;
  logic                        tick_q, tick_d;
  logic [NCO_W:0]              sum;
  logic [NUM_DIGIT-1:0][3:0]   cnt_q, cnt_d;
  logic                        wrap_q, wrap_d;
  logic                        carry;
  logic [SW-1:0]               scan_q, scan_d;
  logic [DW-1:0]               digit_q, digit_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic [NUM_DIGIT-1:0]        enb_q, enb_d;
  logic [NUM_DIGIT-1:0]        blank;
  logic                        hiZero;
  logic [3:0]                  curDigit;

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 7'h3F;
      4'd1:    segCode = 7'h06;
      4'd2:    segCode = 7'h5B;
      4'd3:    segCode = 7'h4F;
      4'd4:    segCode = 7'h66;
      4'd5:    segCode = 7'h6D;
      4'd6:    segCode = 7'h7D;
      4'd7:    segCode = 7'h07;
      4'd8:    segCode = 7'h7F;
      4'd9:    segCode = 7'h6F;
      default: segCode = 7'h00;
    endcase
  endfunction

  // The carry out of the add becomes the registered tick for the next cycle.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, i_nco_num};
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_run) begin
      acc_d  = sum[NCO_W-1:0];
      tick_d = sum[NCO_W];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    carry  = 1'b1;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      for (int i = 0; i < NUM_DIGIT; i++) begin
        cnt_d[i] = (i_load_val[4*i +: 4] > 4'd9) ? 4'd9 : i_load_val[4*i +: 4];
      end
    end else if (tick_q) begin
      // Ripple a carry (up) or borrow (down) from digit 0; survival past the top is a wrap.
      for (int i = 0; i < NUM_DIGIT; i++) begin
        if (carry) begin
          if (i_up) begin
            if (cnt_q[i] == 4'd9) begin
              cnt_d[i] = 4'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 4'd1;
              carry    = 1'b0;
            end
          end else begin
            if (cnt_q[i] == 4'd0) begin
              cnt_d[i] = 4'd9;
            end else begin
              cnt_d[i] = cnt_q[i] - 4'd1;
              carry    = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    scan_d  = scan_q + SW'(1);
    digit_d = digit_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = (digit_q == DW'(NUM_DIGIT - 1)) ? '0 : digit_q + DW'(1);
    end
  end

  // A digit is blanked when it and everything above it is zero, except at or below the dp.
  always_comb begin
    hiZero = 1'b1;
    blank  = '0;
    for (int i = NUM_DIGIT - 1; i >= 0; i--) begin
      hiZero   = hiZero & (cnt_q[i] == 4'd0);
      blank[i] = (LZ_BLANK == 1) && (i != 0) && (i > DP_POS) && hiZero;
    end
    curDigit = cnt_q[digit_q];
    seg_d    = blank[digit_q] ? 7'h00 : segCode(curDigit);
    dp_d     = (int'(digit_q) == DP_POS);
    enb_d    = ~(NUM_DIGIT'(1) << digit_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      digit_q <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      enb_q   <= '1;
    end else begin
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      enb_q   <= enb_d;
    end
  end

  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;
  assign o_seg_enb = enb_q;
  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_nco_cnt_mux_disp.sv
// Bench for nco_cnt_mux_disp: directed scenarios plus random traffic against an
// arithmetic model that treats the counter as an integer modulo 10^6.
module tb_nco_cnt_mux_disp;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    i_nco_num = '0;
  logic          i_run = 1'b0;
  logic          i_up = 1'b1;
  logic          i_clr = 1'b0;
  logic          i_load = 1'b0;
  logic [23:0]   i_load_val = '0;
  logic [6:0]    o_seg;
  logic          o_seg_dp;
  logic [ND-1:0] o_seg_enb;
  logic          o_tick;
  logic          o_wrap;

  int numChecks = 0;
  int numFails  = 0;

  int mAcc, mTick, mCnt, mWrap, mScan, mDig;
  int eSeg, eDp, eEnb;
  int tickCount, wrapCount;

  logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  nco_cnt_mux_disp #(
    .NUM_DIGIT(ND), .NCO_W(8), .SCAN_DIV(4), .DP_POS(2), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_nco_num(i_nco_num), .i_run(i_run),
    .i_up(i_up), .i_clr(i_clr), .i_load(i_load), .i_load_val(i_load_val),
    .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb),
    .o_tick(o_tick), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  function automatic int dispSeg(input int dig, input int cnt);
    int p = 1;
    for (int k = 0; k < dig; k++) p = p * 10;
    if (dig > 2 && cnt < p) return 0;
    return int'(segTab[(cnt / p) % 10]);
  endfunction

  function automatic int loadDecode(input logic [23:0] v);
    int val = 0;
    int p = 1;
    for (int k = 0; k < ND; k++) begin
      int n = int'((v >> (4 * k)) & 24'hF);
      if (n > 9) n = 9;
      val = val + n * p;
      p = p * 10;
    end
    return val;
  endfunction

  task automatic modelReset();
    mAcc = 0; mTick = 0; mCnt = 0; mWrap = 0; mScan = 0; mDig = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_seg"}, 32'(o_seg), 0);
    checkOutput({tag, "_dp"}, 32'(o_seg_dp), 0);
    checkOutput({tag, "_enb"}, 32'(o_seg_enb), 32'h3F);
    checkOutput({tag, "_tick"}, 32'(o_tick), 0);
    checkOutput({tag, "_wrap"}, 32'(o_wrap), 0);
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic applyStimulus(input bit run, input bit up, input bit clr, input bit load,
                               input logic [23:0] lv, input logic [7:0] num);
    int s;
    i_run = run; i_up = up; i_clr = clr; i_load = load; i_load_val = lv; i_nco_num = num;

    eSeg = dispSeg(mDig, mCnt);
    eDp  = (mDig == 2) ? 1 : 0;
    eEnb = ~(1 << mDig) & 32'h3F;

    if (mScan == 3) begin
      mScan = 0;
      mDig  = (mDig + 1) % ND;
    end else begin
      mScan++;
    end

    mWrap = 0;
    if (clr) mCnt = 0;
    else if (load) mCnt = loadDecode(lv);
    else if (mTick != 0) begin
      if (up) begin
        if (mCnt == 999999) begin mCnt = 0; mWrap = 1; end
        else mCnt = mCnt + 1;
      end else begin
        if (mCnt == 0) begin mCnt = 999999; mWrap = 1; end
        else mCnt = mCnt - 1;
      end
    end

    if (clr) begin
      mAcc = 0; mTick = 0;
    end else if (run) begin
      s     = mAcc + int'(num);
      mTick = (s >= 256) ? 1 : 0;
      mAcc  = s % 256;
    end else begin
      mTick = 0;
    end

    @(posedge clk);
    #1;
    checkOutput("tick", 32'(o_tick), 32'(mTick));
    checkOutput("wrap", 32'(o_wrap), 32'(mWrap));
    checkOutput("seg",  32'(o_seg), 32'(eSeg));
    checkOutput("dp",   32'(o_seg_dp), 32'(eDp));
    checkOutput("enb",  32'(o_seg_enb), 32'(eEnb));
    if (o_tick) tickCount++;
    if (o_wrap) wrapCount++;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 checkResetOutputs("rst_async");
    @(posedge clk);
    #1 checkResetOutputs("rst_held");
    rst_n = 1'b1;
    modelReset();

    // Eight-bit NCO stepping by 64 overflows every fourth cycle.
    applyStimulus(0, 1, 1, 0, '0, 8'd0);
    tickCount = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 0, '0, 8'd64);
    checkOutput("ticks_in_16", 32'(tickCount), 4);

    // Up across the top: 999998 -> 999999 -> 000000 with a single wrap.
    applyStimulus(0, 1, 1, 0, '0, 8'd0);
    applyStimulus(0, 1, 0, 1, 24'h999998, 8'd0);
    wrapCount = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, '0, 8'd128);
    checkOutput("wraps_up", 32'(wrapCount), 1);

    // Down from zero wraps to all nines; a clear coincident with a tick wins.
    applyStimulus(0, 0, 1, 0, '0, 8'd0);
    wrapCount = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, '0, 8'd128);
    checkOutput("wraps_down", 32'(wrapCount), 1);
    applyStimulus(1, 0, 0, 0, '0, 8'd128);
    applyStimulus(0, 0, 1, 0, '0, 8'd0);
    applyStimulus(0, 0, 0, 0, '0, 8'd0);

    // Full scan with blanking and decimal point, then a saturated non-BCD nibble.
    applyStimulus(0, 1, 0, 1, 24'h000123, 8'd0);
    for (int i = 0; i < 28; i++) applyStimulus(0, 1, 0, 0, '0, 8'd0);
    applyStimulus(0, 1, 0, 1, 24'h0000C5, 8'd0);
    for (int i = 0; i < 28; i++) applyStimulus(0, 1, 0, 0, '0, 8'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                    24'($urandom), 8'($urandom));
    end

    // Asynchronous reset between edges while counting, then resume from zero.
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, '0, 8'd200);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("rst_mid");
    modelReset();
    @(posedge clk);
    #1 checkResetOutputs("rst_mid_held");
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0, 0, '0, 8'd100);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/nco_cnt_mux_disp.md
NCO_CNT_MUX_DISP -- requirements
Module: nco_cnt_mux_disp

Interface
REQ-001 Parameter NUM_DIGIT, default 6: number of BCD digits counted and displayed (2..8).
REQ-002 Parameter NCO_W, default 32: NCO phase-accumulator width.
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per displayed digit (1 ms at 50 MHz).
REQ-004 Parameter DP_POS, default 2: digit index whose decimal point is lit; a value >= NUM_DIGIT disables the decimal point.
REQ-005 Parameter LZ_BLANK, default 1: a value of 1 enables leading-zero blanking.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_nco_num  in  NCO_W  NCO phase increment; tick rate = f_clk*i_nco_num/2^NCO_W.
REQ-009 i_run  in  1  high enables NCO accumulation.
REQ-010 i_up  in  1  count direction: 1 = up, 0 = down.
REQ-011 i_clr  in  1  synchronous clear of counter and accumulator.
REQ-012 i_load  in  1  synchronous load of i_load_val into counter.
REQ-013 i_load_val  in  4*NUM_DIGIT  BCD load value, digit 0 in bits [3:0].
REQ-014 o_seg  out  7  segments {g,f,e,d,c,b,a}, active-high lit.
REQ-015 o_seg_dp  out  1  decimal point, active-high lit.
REQ-016 o_seg_enb  out  NUM_DIGIT  digit enables, one-hot active-low.
REQ-017 o_tick  out  1  one-cycle pulse on NCO overflow.
REQ-018 o_wrap  out  1  one-cycle pulse when the counter wraps.

Function
REQ-019 While i_run=1, the accumulator SHALL add i_nco_num each cycle modulo 2^NCO_W; a carry out SHALL assert o_tick on the following cycle.
REQ-020 While i_run=0, the accumulator SHALL hold its value and o_tick SHALL stay 0.
REQ-021 The counter SHALL be NUM_DIGIT BCD digits, with each digit restricted to 0..9 at all times.
REQ-022 A tick with i_up=1 SHALL increment the counter with decimal ripple carry; a tick with i_up=0 SHALL decrement it with decimal borrow.
REQ-023 Up from all-9s SHALL give all-0s; down from all-0s SHALL give all-9s; either case SHALL pulse o_wrap in the same cycle the counter updates.
REQ-024 Priority per cycle SHALL be i_clr > i_load > tick.
- Clear zeroes the counter and the accumulator.
- Load ignores a coincident tick and produces no o_wrap.
REQ-025 A non-BCD nibble (>9) in i_load_val SHALL load as 9.
REQ-026 A scan counter SHALL count 0..SCAN_DIV-1 and then advance the digit index 0,1,..,NUM_DIGIT-1,0.
REQ-027 Display outputs SHALL be registered and SHALL reflect the current digit index and counter value one cycle later.
REQ-028 For the active digit i, the outputs SHALL be:
- o_seg_enb bit i = 0, all other bits = 1.
- o_seg = standard 7-segment code of digit i (0 = 7'h3F, 1 = 7'h06, ..., 9 = 7'h6F).
- o_seg_dp = 1 only when i == DP_POS.
REQ-029 When LZ_BLANK=1, digit i SHALL show o_seg=0 if it and every higher digit are 0, unless i == 0 or i <= DP_POS; its enable still asserts.
REQ-030 Changes to i_nco_num SHALL take effect on the next accumulation and SHALL NOT reset the accumulator.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, set the following, and hold them until released:
- accumulator, counter, scan counter and digit index = 0;
- o_seg=0, o_seg_dp=0, o_seg_enb all 1s, o_tick=0, o_wrap=0.
REQ-032 After the rst_n rising edge, the first display update SHALL occur on the next clk edge, showing digit 0.
REQ-033 Reset asserted mid-tick or mid-scan SHALL discard all state; no pending tick or wrap SHALL survive reset.

Verification
REQ-034 NCO_W=8, i_nco_num=64, i_run=1 for 16 cycles -> exactly 4 o_tick pulses, spaced 4 cycles apart.
REQ-035 NUM_DIGIT=2, i_load with 8'h98, i_up=1, then 2 ticks -> counter 99 then 00, with o_wrap pulsing on the second tick only.
REQ-036 Counter 00, i_up=0, 1 tick -> counter 99 and o_wrap=1; then i_clr together with a tick -> counter 00 and no o_wrap.
REQ-037 SCAN_DIV=4, NUM_DIGIT=6, counter 000123, DP_POS=2, LZ_BLANK=1 -> over 24 cycles, each digit is enabled for 4 cycles with enables 6'b111110, 6'b111101, ... Digits 0-2 show 3, 2, 1 (7'h4F, 7'h5B, 7'h06), with dp lit on digit 2 only. Digits 3-5 show o_seg=0.
REQ-038 rst_n pulled low between clk edges during counting -> all outputs take their reset values immediately, with no clk edge. After release the count resumes from 0.
REQ-039 i_load_val nibble 4'hC loaded into digit 1 -> counter digit 1 reads 9, and the display shows 7'h6F on digit 1.
